// File: rtl/lsu_pkg.sv
// Shared memop encodings, FSM state encoding and access-size decode for the load/store unit.
// Combinational helpers only; no latency, no backpressure.
package lsu_pkg;

    localparam logic [2:0] MOP_W  = 3'b000;
    localparam logic [2:0] MOP_B  = 3'b001;
    localparam logic [2:0] MOP_H  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b101;
    localparam logic [2:0] MOP_HU = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B0   = 3'd1,
        S_B1   = 3'd2,
        S_FIN  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    function automatic logic mop_legal(input logic [2:0] mop);
        case (mop)
            MOP_W, MOP_B, MOP_H, MOP_BU, MOP_HU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // Right-justified byte-lane mask for the access size (1, 2 or 4 bytes).
    function automatic logic [3:0] mop_mask(input logic [2:0] mop);
        case (mop[1:0])
            2'b01:   return 4'b0001;
            2'b10:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // An access is split when it runs past the end of its first word.
    function automatic logic mop_split(input logic [2:0] mop, input logic [1:0] off);
        case (mop[1:0])
            2'b01:   return 1'b0;
            2'b10:   return (off == 2'd3);
            default: return (off != 2'd0);
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and data-RAM port bundle for the load/store unit.
// No logic; master is the load/store unit, slave is the core/RAM side.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_memop;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_memop, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_memop, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_en, mem_we, mem_addr, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Positions store data/mask into byte lanes across two words and extracts/extends load data.
// Purely combinational, zero latency, no backpressure.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  memop,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword0,
    input  logic [31:0] rword1,
    output logic [7:0]  m8,
    output logic [63:0] d64,
    output logic [31:0] rdata
);
    logic [31:0] r32;

    always_comb begin
        m8    = {4'b0000, mop_mask(memop)} << off;
        d64   = {32'h0, wdata} << {off, 3'b000};
        r32   = 32'({rword1, rword0} >> {off, 3'b000});
        case (memop)
            MOP_B:   rdata = {{24{r32[7]}}, r32[7:0]};
            MOP_BU:  rdata = {24'h0, r32[7:0]};
            MOP_H:   rdata = {{16{r32[15]}}, r32[15:0]};
            MOP_HU:  rdata = {16'h0, r32[15:0]};
            default: rdata = r32;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one core load/store per handshake, split into 1-2 word beats, one-cycle response.
// Latency accept->resp: 1 (error), 2/3 (store), 3/4 (load). req_ready only while idle; one transaction in flight.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic ALLOW_MISALIGNED = 1'b1
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.master bus
);
    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  memop_q, memop_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        split_q, split_d;
    logic [31:0] w0_q, w0_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [7:0]  m8;
    logic [63:0] d64;
    logic [31:0] ext_rdata;
    logic [31:0] word0_addr;
    logic        bad_req;

    // In FIN the live RAM word is the last beat: upper word when split, the only word otherwise.
    lsu_lane_align u_align (
        .memop  (memop_q),
        .off    (addr_q[1:0]),
        .wdata  (wdata_q),
        .rword0 (split_q ? w0_q : bus.mem_rdata),
        .rword1 (split_q ? bus.mem_rdata : 32'h0),
        .m8     (m8),
        .d64    (d64),
        .rdata  (ext_rdata)
    );

    assign word0_addr = {addr_q[31:2], 2'b00};
    assign bad_req    = !mop_legal(bus.req_memop)
                     || (mop_split(bus.req_memop, bus.req_addr[1:0]) && !ALLOW_MISALIGNED);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        memop_d = memop_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        split_d = split_q;
        w0_d    = w0_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = 32'h0;
        bus.mem_wmask  = 4'h0;
        bus.mem_wdata  = 32'h0;

        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    memop_d = bus.req_memop;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    split_d = mop_split(bus.req_memop, bus.req_addr[1:0]);
                    if (bad_req) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_B0;
                    end
                end
            end
            S_B0: begin
                bus.mem_en   = 1'b1;
                bus.mem_we   = we_q;
                bus.mem_addr = word0_addr;
                if (we_q) begin
                    bus.mem_wmask = m8[3:0];
                    bus.mem_wdata = d64[31:0];
                end
                if (split_q) begin
                    state_d = S_B1;
                end else if (we_q) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_B1: begin
                bus.mem_en   = 1'b1;
                bus.mem_we   = we_q;
                bus.mem_addr = word0_addr + 32'd4;
                if (we_q) begin
                    bus.mem_wmask = m8[7:4];
                    bus.mem_wdata = d64[63:32];
                    rdata_d       = 32'h0;
                    err_d         = 1'b0;
                    state_d       = S_RESP;
                end else begin
                    w0_d    = bus.mem_rdata;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                rdata_d = ext_rdata;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A cycle held in reset must not touch memory or signal anything to the core.
        if (!rst_n) begin
            bus.req_ready  = 1'b0;
            bus.resp_valid = 1'b0;
            bus.mem_en     = 1'b0;
            bus.mem_we     = 1'b0;
            bus.mem_wmask  = 4'h0;
        end

        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            memop_q <= MOP_W;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            split_q <= 1'b0;
            w0_q    <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            memop_q <= memop_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            split_q <= split_d;
            w0_q    <= w0_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance with misaligned splitting, one without,
// sharing a small word RAM model; table of transactions plus reset-abandon sequence.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if if1 ();
    lsu_if if0 ();

    load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(if1));
    load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_na (.clk(clk), .rst_n(rst_n), .bus(if0));

    logic        sel = 1'b1;
    logic        t_valid = 1'b0;
    logic        t_we = 1'b0;
    logic [2:0]  t_mop = 3'b000;
    logic [31:0] t_addr = 32'h0;
    logic [31:0] t_wdata = 32'h0;
    logic [31:0] ram [0:255];
    logic [31:0] ram_rdata = 32'h0;

    assign if1.req_valid = t_valid & sel;
    assign if0.req_valid = t_valid & ~sel;
    assign if1.req_we = t_we;     assign if0.req_we = t_we;
    assign if1.req_memop = t_mop; assign if0.req_memop = t_mop;
    assign if1.req_addr = t_addr; assign if0.req_addr = t_addr;
    assign if1.req_wdata = t_wdata; assign if0.req_wdata = t_wdata;
    assign if1.mem_rdata = ram_rdata; assign if0.mem_rdata = ram_rdata;

    logic        m_en, m_we, r_valid, r_err, r_ready;
    logic [31:0] m_addr, m_wdata, r_rdata;
    logic [3:0]  m_mask;
    assign m_en    = sel ? if1.mem_en : if0.mem_en;
    assign m_we    = sel ? if1.mem_we : if0.mem_we;
    assign m_addr  = sel ? if1.mem_addr : if0.mem_addr;
    assign m_mask  = sel ? if1.mem_wmask : if0.mem_wmask;
    assign m_wdata = sel ? if1.mem_wdata : if0.mem_wdata;
    assign r_valid = sel ? if1.resp_valid : if0.resp_valid;
    assign r_rdata = sel ? if1.resp_rdata : if0.resp_rdata;
    assign r_err   = sel ? if1.resp_err : if0.resp_err;
    assign r_ready = sel ? if1.req_ready : if0.req_ready;

    always @(posedge clk) begin
        if (m_en && !m_we) ram_rdata <= ram[m_addr[9:2]];
    end

    typedef struct {
        logic        sel;
        logic        we;
        logic [2:0]  mop;
        logic [31:0] addr, wdata, i0, i1;
        int          lat, nb;
        logic [31:0] a0; logic [3:0] m0; logic [31:0] d0;
        logic [31:0] a1; logic [3:0] m1; logic [31:0] d1;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t vecs [14];
    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        int          lat, nb;
        logic [31:0] ba [2];
        logic [3:0]  bm [2];
        logic [31:0] bd [2];
        logic        bw [2];
        logic [31:0] rd;
        logic        er;
        logic [7:0]  idx;

        //            sel   we    mop     addr          wdata         i0            i1           lat nb a0            m0    d0            a1           m1    d1            rd            err
        vecs[0]  = '{1'b1, 1'b1, 3'b000, 32'h100,      32'hDEADBEEF, 32'h0,        32'h0,        2, 1, 32'h100,      4'hF, 32'hDEADBEEF, 32'h0,       4'h0, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b001, 32'h103,      32'h0,        32'h80123456, 32'h0,        3, 1, 32'h100,      4'h0, 32'h0,        32'h0,       4'h0, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b101, 32'h103,      32'h0,        32'h80123456, 32'h0,        3, 1, 32'h100,      4'h0, 32'h0,        32'h0,       4'h0, 32'h0,        32'h00000080, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b000, 32'h102,      32'h0,        32'h44332211, 32'h88776655, 4, 2, 32'h100,      4'h0, 32'h0,        32'h104,     4'h0, 32'h0,        32'h66554433, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 3'b010, 32'h0FF,      32'h0000ABCD, 32'h0,        32'h0,        3, 2, 32'h0FC,      4'h8, 32'hCD000000, 32'h100,     4'h1, 32'h000000AB, 32'h0,        1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b011, 32'h100,      32'h0,        32'h0,        32'h0,        1, 0, 32'h0,        4'h0, 32'h0,        32'h0,       4'h0, 32'h0,        32'h0,        1'b1};
        vecs[6]  = '{1'b0, 1'b0, 3'b000, 32'h101,      32'h0,        32'h0,        32'h0,        1, 0, 32'h0,        4'h0, 32'h0,        32'h0,       4'h0, 32'h0,        32'h0,        1'b1};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h102,      32'h0,        32'h80011234, 32'h0,        3, 1, 32'h100,      4'h0, 32'h0,        32'h0,       4'h0, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b110, 32'h102,      32'h0,        32'h80011234, 32'h0,        3, 1, 32'h100,      4'h0, 32'h0,        32'h0,       4'h0, 32'h0,        32'h00008001, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 3'b001, 32'h101,      32'h1234565A, 32'h0,        32'h0,        2, 1, 32'h100,      4'h2, 32'h34565A00, 32'h0,       4'h0, 32'h0,        32'h0,        1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h103,      32'h0,        32'hAA000000, 32'h000000BB, 4, 2, 32'h100,      4'h0, 32'h0,        32'h104,     4'h0, 32'h0,        32'hFFFFBBAA, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 3'b000, 32'hFFFFFFFE, 32'h11223344, 32'h0,        32'h0,        3, 2, 32'hFFFFFFFC, 4'hC, 32'h33440000, 32'h0,       4'h3, 32'h00001122, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 1'b1, 3'b010, 32'h101,      32'h0000ABCD, 32'h0,        32'h0,        2, 1, 32'h100,      4'h6, 32'h00ABCD00, 32'h0,       4'h0, 32'h0,        32'h0,        1'b0};
        vecs[13] = '{1'b0, 1'b0, 3'b000, 32'h104,      32'h0,        32'h88776655, 32'h0,        3, 1, 32'h104,      4'h0, 32'h0,        32'h0,       4'h0, 32'h0,        32'h88776655, 1'b0};

        for (int i = 0; i < 256; i++) ram[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, r_ready}, 32'h0);
        chk("rst_mem_en", {31'h0, if1.mem_en | if0.mem_en}, 32'h0);
        chk("rst_mem_we", {31'h0, if1.mem_we | if0.mem_we}, 32'h0);
        chk("rst_wmask", {28'h0, if1.mem_wmask | if0.mem_wmask}, 32'h0);
        chk("rst_resp_valid", {31'h0, if1.resp_valid | if0.resp_valid}, 32'h0);
        chk("rst_resp_rdata", if1.resp_rdata | if0.resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, if1.resp_err | if0.resp_err}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 14; v++) begin
            idx = vecs[v].addr[9:2];
            ram[idx] = vecs[v].i0;
            ram[idx + 8'd1] = vecs[v].i1;
            sel     = vecs[v].sel;
            t_we    = vecs[v].we;
            t_mop   = vecs[v].mop;
            t_addr  = vecs[v].addr;
            t_wdata = vecs[v].wdata;
            t_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_ready", v), {31'h0, r_ready}, 32'h1);
            @(posedge clk);
            #1 t_valid = 1'b0;
            lat = 0; nb = 0; rd = 32'h0; er = 1'b0;
            for (int k = 0; k < 2; k++) begin ba[k] = 0; bm[k] = 0; bd[k] = 0; bw[k] = 0; end
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (m_en) begin
                    if (nb < 2) begin
                        ba[nb] = m_addr; bm[nb] = m_mask; bd[nb] = m_wdata; bw[nb] = m_we;
                    end
                    nb++;
                end
                if (r_valid) begin
                    lat = c; rd = r_rdata; er = r_err;
                    break;
                end
            end
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            chk($sformatf("v%0d_beats", v), 32'(nb), 32'(vecs[v].nb));
            chk($sformatf("v%0d_rdata", v), rd, vecs[v].rd);
            chk($sformatf("v%0d_err", v), {31'h0, er}, {31'h0, vecs[v].err});
            if (vecs[v].nb >= 1) begin
                chk($sformatf("v%0d_b0_addr", v), ba[0], vecs[v].a0);
                chk($sformatf("v%0d_b0_mask", v), {28'h0, bm[0]}, {28'h0, vecs[v].m0});
                chk($sformatf("v%0d_b0_we", v), {31'h0, bw[0]}, {31'h0, vecs[v].we});
                if (vecs[v].we) chk($sformatf("v%0d_b0_data", v), bd[0], vecs[v].d0);
            end
            if (vecs[v].nb == 2) begin
                chk($sformatf("v%0d_b1_addr", v), ba[1], vecs[v].a1);
                chk($sformatf("v%0d_b1_mask", v), {28'h0, bm[1]}, {28'h0, vecs[v].m1});
                chk($sformatf("v%0d_b1_we", v), {31'h0, bw[1]}, {31'h0, vecs[v].we});
                if (vecs[v].we) chk($sformatf("v%0d_b1_data", v), bd[1], vecs[v].d1);
            end
            // Response is a single-cycle pulse; data and error hold afterwards.
            @(negedge clk);
            chk($sformatf("v%0d_pulse", v), {31'h0, r_valid}, 32'h0);
            chk($sformatf("v%0d_hold_rdata", v), r_rdata, vecs[v].rd);
            chk($sformatf("v%0d_hold_err", v), {31'h0, r_err}, {31'h0, vecs[v].err});
        end

        // Reset during beat 1 of a split store abandons it.
        sel = 1'b1; t_we = 1'b1; t_mop = 3'b010; t_addr = 32'h0FF; t_wdata = 32'h0000ABCD;
        t_valid = 1'b1;
        @(posedge clk);
        #1 t_valid = 1'b0;
        @(negedge clk);
        chk("abort_b0_mem_en", {31'h0, m_en}, 32'h1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_b1_mem_en", {31'h0, m_en}, 32'h0);
        chk("abort_b1_mem_we", {31'h0, m_we}, 32'h0);
        chk("abort_b1_ready", {31'h0, r_ready}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("abort_c%0d_resp_valid", c), {31'h0, r_valid}, 32'h0);
            chk($sformatf("abort_c%0d_mem_en", c), {31'h0, m_en}, 32'h0);
            chk($sformatf("abort_c%0d_ready", c), {31'h0, r_ready}, 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
